axi_ram_slave: RTL and testbench
================================

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, giving log2 of memory depth in 32-bit words.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port arid  in  4  read ID.
REQ-005 SHALL have port araddr  in  32  read byte address.
REQ-006 SHALL have port arlen  in  8  read beats minus one.
REQ-007 SHALL have port arvalid  in  1  AR valid.
REQ-008 SHALL have port arready  out  1  AR ready.
REQ-009 SHALL have port rid  out  4  read response ID.
REQ-010 SHALL have port rdata  out  32  read data.
REQ-011 SHALL have port rresp  out  2  read response.
REQ-012 SHALL have port rlast  out  1  final read beat.
REQ-013 SHALL have port rvalid  out  1  R valid.
REQ-014 SHALL have port rready  in  1  R ready.
REQ-015 SHALL have port awid  in  4  write ID.
REQ-016 SHALL have port awaddr  in  32  write byte address.
REQ-017 SHALL have port awlen  in  8  write beats minus one.
REQ-018 SHALL have port awvalid  in  1  AW valid.
REQ-019 SHALL have port awready  out  1  AW ready.
REQ-020 SHALL have port wdata  in  32  write data.
REQ-021 SHALL have port wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i].
REQ-022 SHALL have port wlast  in  1  final write beat marker.
REQ-023 SHALL have port wvalid  in  1  W valid.
REQ-024 SHALL have port wready  out  1  W ready.
REQ-025 SHALL have port bid  out  4  write response ID.
REQ-026 SHALL have port bresp  out  2  write response.
REQ-027 SHALL have port bvalid  out  1  B valid.
REQ-028 SHALL have port bready  in  1  B ready.

Function
REQ-029 SHALL hold 2^MEM_AW words; word index = addr[MEM_AW+1:2]; addr[1:0] and upper bits ignored (aliasing); burst type is always INCR, beat size always 4 bytes.
REQ-030 SHALL run read FSM R_IDLE/R_DATA and write FSM W_IDLE/W_DATA/W_RESP independently; both may be active in the same cycle.
REQ-031 R_IDLE: arready=1, rvalid=0; on arvalid&&arready latch arid, index, arlen, clear beat count, load rdata=mem[index], go R_DATA (rvalid=1 the next cycle).
REQ-032 R_DATA: arready=0, rvalid=1, rid=latched ID, rresp=2'b00, rlast=1 only when beat count == latched len; rdata held stable while rready=0.
REQ-033 On R handshake with rlast=0: index+1 (wrapping modulo 2^MEM_AW), count+1, rdata=mem[new index] next cycle, rvalid stays 1 (no bubble).
REQ-034 On R handshake with rlast=1: go R_IDLE; rvalid=0 and arready=1 the next cycle.
REQ-035 W_IDLE: awready=1, wready=0, bvalid=0; on AW handshake latch awid, index, awlen, clear count and error flag, go W_DATA.
REQ-036 W_DATA: awready=0, wready=1; on each W handshake write enabled bytes of mem[index], index+1 (wrapping), count+1; disabled bytes unchanged.
REQ-037 Burst SHALL end on the beat where count == latched awlen, regardless of wlast; any beat where wlast != (count == awlen) sets error flag.
REQ-038 After the final W beat: wready=0, go W_RESP; bvalid=1, bid=latched ID, bresp=2'b10 (SLVERR) if error flag else 2'b00.
REQ-039 W_RESP: on bvalid&&bready go W_IDLE; awready=1 the next cycle.
REQ-040 Same-word read load and write in the same cycle: the read SHALL return the pre-write value.
REQ-041 arlen/awlen = 255 SHALL give 256 beats; bursts crossing the top of memory wrap to index 0.

Reset
REQ-042 On reset: both FSMs to idle; arready=0, awready=0 during reset, 1 the first cycle after release; rvalid=wready=bvalid=rlast=0; rid=bid=0, rresp=bresp=0, rdata=0; memory contents unspecified and not cleared; reset mid-burst abandons the burst with no response.

Verification
REQ-043 Single write awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF, wlast=1 -> bvalid with bresp=0, bid=awid; then read araddr=0x10 -> rdata=0xDEADBEEF, rlast=1.
REQ-044 Byte write wstrb=4'b0010, wdata=0x0000AB00 over 0xDEADBEEF -> read returns 0xDEADABEF.
REQ-045 4-beat read arlen=3 at word 2^MEM_AW-2 with rready toggled every cycle -> beats from words 2^MEM_AW-2, 2^MEM_AW-1, 0, 1; rlast only on 4th; data stable while stalled.
REQ-046 Write awlen=1 with wlast=1 on first beat -> exactly 2 beats accepted, bresp=2'b10.
REQ-047 Concurrent read and write to the same word in the same cycle -> read returns old value, later read returns new.
REQ-048 Reset asserted mid write burst -> all valid/ready outputs low asynchronously; after release awready=arready=1 and a fresh transaction completes normally.

Source files
------------

// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by a 2^MEM_AW x 32-bit RAM, with independent read and write burst engines.
// Latency: R data follows the AR handshake by one cycle, and beats stream back-to-back.
//          B follows the final W beat by one cycle.
// Backpressure: rdata/rlast are held while rready is low. The B response is held until bready is high.
//               A new AR or AW is refused while its burst is still in flight.
// Ports: clk/reset; AR (arid, araddr, arlen, arvalid, arready); R (rid, rdata, rresp, rlast, rvalid, rready);
//        AW (awid, awaddr, awlen, awvalid, awready); W (wdata, wstrb, wlast, wvalid, wready);
//        B (bid, bresp, bvalid, bready).
module axi_ram_slave #(
    parameter int MEM_AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    // This flag is cleared by reset and set on the first edge after release.
    // It keeps arready and awready low for the whole time reset is asserted,
    // even though both FSMs sit in their idle states during reset.
    logic run;

    logic [0:0]        r_state;
    logic [MEM_AW-1:0] r_idx;
    logic [MEM_AW-1:0] r_idx_inc;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;

    logic [1:0]        w_state;
    logic [MEM_AW-1:0] w_idx;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic              w_err;
    logic              w_final;
    logic              w_beat_err;

    logic ar_hs;
    logic aw_hs;
    logic w_hs;

    // Address bits above the RAM depth alias. The byte-offset bits are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};

    assign arready = run && (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);
    assign rlast   = rvalid && (r_cnt == r_len);
    assign rresp   = 2'b00;
    assign ar_hs   = arvalid && arready;

    // Index arithmetic is MEM_AW bits wide, so bursts wrap at the top of the RAM.
    assign r_idx_inc = r_idx + MEM_AW'(1);

    assign awready = run && (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // The burst length comes from awlen alone. wlast is only checked against it.
    assign w_final    = (w_cnt == w_len);
    assign w_beat_err = (wlast != w_final);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Read engine. The next word is fetched on the same edge that accepts the
    // current beat, so rvalid stays high across the whole burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            rid     <= '0;
            rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rid     <= arid;
                        r_idx   <= araddr[MEM_AW+1:2];
                        r_len   <= arlen;
                        r_cnt   <= '0;
                        rdata   <= mem[araddr[MEM_AW+1:2]];
                        r_state <= R_DATA;
                    end
                end
                default: begin
                    if (rready) begin
                        if (rlast) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_idx <= r_idx_inc;
                            r_cnt <= r_cnt + 8'd1;
                            rdata <= mem[r_idx_inc];
                        end
                    end
                end
            endcase
        end
    end

    // Write engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            bid     <= '0;
            bresp   <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        bid     <= awid;
                        w_idx   <= awaddr[MEM_AW+1:2];
                        w_len   <= awlen;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_idx <= w_idx + MEM_AW'(1);
                        w_cnt <= w_cnt + 8'd1;
                        w_err <= w_err || w_beat_err;
                        if (w_final) begin
                            // Fold in the final beat's own wlast mismatch.
                            bresp   <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // RAM write port. The RAM itself is never reset.
    // w_hs is forced low during reset because the write FSM is held in idle.
    // A read fetch and a write to the same word on the same edge returns the old word.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave, default depth of 1024 words.
// Inputs are driven and outputs are sampled on the falling clock edge.
// Handshakes complete on the following rising edge.
module tb_axi_ram_slave;

    logic        clk;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int pass_cnt = 0;
    int total    = 0;

    logic [31:0] wrap_dat [4];

    axi_ram_slave #(.MEM_AW(10)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        for (int n = 0; n < 50 && !awready; n++) @(negedge clk);
        chk("aw_ready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        for (int n = 0; n < 50 && !wready; n++) @(negedge clk);
        chk("w_ready", wready, 1);
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic b_check(input string tag, input logic [3:0] id, input logic [1:0] resp);
        bready = 1'b1;
        for (int n = 0; n < 50 && !bvalid; n++) @(negedge clk);
        chk({tag, "_bvalid"}, bvalid, 1);
        chk({tag, "_bid"}, bid, id);
        chk({tag, "_bresp"}, bresp, resp);
        @(negedge clk);
        bready = 1'b0;
        chk({tag, "_awready_after_b"}, awready, 1);
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        for (int n = 0; n < 50 && !arready; n++) @(negedge clk);
        chk("ar_ready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic r_beat(input string tag, input logic [3:0] id, input logic [31:0] d, input logic l);
        rready = 1'b1;
        for (int n = 0; n < 50 && !rvalid; n++) @(negedge clk);
        chk({tag, "_rvalid"}, rvalid, 1);
        chk({tag, "_rdata"}, rdata, d);
        chk({tag, "_rlast"}, rlast, l);
        chk({tag, "_rid"}, rid, id);
        chk({tag, "_rresp"}, rresp, 0);
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        wrap_dat[0] = 32'hA0A0_0001; wrap_dat[1] = 32'hA1A1_0002;
        wrap_dat[2] = 32'hA2A2_0003; wrap_dat[3] = 32'hA3A3_0004;

        // Output values while reset is asserted.
        repeat (2) @(negedge clk);
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ids", {rid, bid}, 0);
        chk("rst_resps", {rresp, bresp}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_arready", arready, 1);
        chk("rel_awready", awready, 1);

        // Single-beat full-word write, then read it back.
        do_aw(4'h5, 32'h10, 8'd0);
        w_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
        b_check("w1", 4'h5, 2'b00);
        do_ar(4'h3, 32'h10, 8'd0);
        r_beat("r1", 4'h3, 32'hDEAD_BEEF, 1'b1);
        chk("r1_idle_arready", arready, 1);

        // Write with only byte 1 enabled.
        do_aw(4'h6, 32'h10, 8'd0);
        w_beat(32'h0000_AB00, 4'b0010, 1'b1);
        b_check("wb", 4'h6, 2'b00);
        do_ar(4'h4, 32'h10, 8'd0);
        r_beat("rb", 4'h4, 32'hDEAD_ABEF, 1'b1);

        // 4-beat write that wraps from word 1022 to word 1.
        do_aw(4'h1, 32'hFF8, 8'd3);
        for (int b = 0; b < 4; b++) w_beat(wrap_dat[b], 4'hF, b == 3);
        b_check("wwrap", 4'h1, 2'b00);

        // 4-beat read of the same words with rready toggled every cycle.
        do_ar(4'h7, 32'hFF8, 8'd3);
        for (int b = 0; b < 4; b++) begin
            rready = 1'b0;
            chk($sformatf("rwrap%0d_vld_stall", b), rvalid, 1);
            chk($sformatf("rwrap%0d_dat_stall", b), rdata, wrap_dat[b]);
            chk($sformatf("rwrap%0d_last_stall", b), rlast, b == 3);
            @(negedge clk);
            rready = 1'b1;
            chk($sformatf("rwrap%0d_dat_held", b), rdata, wrap_dat[b]);
            chk($sformatf("rwrap%0d_last", b), rlast, b == 3);
            chk($sformatf("rwrap%0d_rid", b), rid, 4'h7);
            @(negedge clk);
        end
        rready = 1'b0;
        chk("rwrap_done_rvalid", rvalid, 0);
        chk("rwrap_done_arready", arready, 1);

        // awlen=1 with wlast on both beats: burst ends after 2 beats with SLVERR.
        do_aw(4'h2, 32'h40, 8'd1);
        w_beat(32'h1111_1111, 4'hF, 1'b1);
        chk("early_last_still_wready", wready, 1);
        w_beat(32'h2222_2222, 4'hF, 1'b1);
        chk("early_last_wready_off", wready, 0);
        b_check("werr", 4'h2, 2'b10);
        do_ar(4'h8, 32'h40, 8'd1);
        r_beat("rerr0", 4'h8, 32'h1111_1111, 1'b0);
        r_beat("rerr1", 4'h8, 32'h2222_2222, 1'b1);

        // Read fetch and write to word 0x20 on the same edge.
        do_aw(4'hB, 32'h80, 8'd0);
        w_beat(32'h1234_5678, 4'hF, 1'b1);
        b_check("wold", 4'hB, 2'b00);
        do_aw(4'hC, 32'h80, 8'd0);
        wdata = 32'h9ABC_DEF0; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        arid = 4'h2; araddr = 32'h80; arlen = 8'd0; arvalid = 1'b1;
        chk("conc_both_ready", {wready, arready}, 2'b11);
        @(negedge clk);
        wvalid = 1'b0; arvalid = 1'b0;
        r_beat("conc_old", 4'h2, 32'h1234_5678, 1'b1);
        b_check("conc_b", 4'hC, 2'b00);
        do_ar(4'h3, 32'h80, 8'd0);
        r_beat("conc_new", 4'h3, 32'h9ABC_DEF0, 1'b1);

        // Reset during a write burst, with a read also pending.
        do_aw(4'h9, 32'h300, 8'd3);
        w_beat(32'h5555_5555, 4'hF, 1'b0);
        do_ar(4'hA, 32'h10, 8'd0);
        chk("pre_rst_rvalid", rvalid, 1);
        chk("pre_rst_wready", wready, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_awready", awready, 0);
        chk("arst_arready", arready, 0);
        chk("arst_wready", wready, 0);
        chk("arst_rvalid", rvalid, 0);
        chk("arst_bvalid", bvalid, 0);
        chk("arst_rlast", rlast, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);
        chk("post_rst_bvalid", bvalid, 0);
        do_aw(4'h3, 32'h200, 8'd0);
        w_beat(32'hCAFE_F00D, 4'hF, 1'b1);
        b_check("wfresh", 4'h3, 2'b00);
        do_ar(4'hD, 32'h200, 8'd0);
        r_beat("rfresh", 4'hD, 32'hCAFE_F00D, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
